// File: rtl/div_seq_pkg.sv
// div_seq_pkg
// Shared definitions for the sequential divider: default operand widths,
// FSM state encoding and the iteration-counter width.
// No ports; imported by div_seq_if, div_step and div_seq.
package div_seq_pkg;

  localparam int DIVISOR_W_DEF  = 25;
  localparam int DIVIDEND_W_DEF = 2 * DIVISOR_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count 0..w without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DIVISOR_W_DEF);

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if
// Request/result bundle of the sequential divider.
//   start, dividend, divisor : request side (driven by master)
//   busy, done, quotient, remainder, div_by_zero, overflow : result side
// Modports: master (requester), slave (divider).
interface div_seq_if import div_seq_pkg::*; #(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) ();

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVISOR_W-1:0]  quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/div_step.sv
// div_step
// One radix-2 restoring-division iteration, purely combinational.
//   rem_in  : partial remainder before the step (always < divisor)
//   bit_in  : next dividend bit, MSB first
//   divisor : divisor
//   rem_out : partial remainder after the step
//   q_bit   : quotient bit produced by the step
module div_step import div_seq_pkg::*; #(
  parameter int W = DIVISOR_W_DEF
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // The difference is only W+1 bits wide. If the shifted value already has
  // its top bit set it exceeds any W-bit divisor; otherwise diff[W] is the
  // borrow and flags a negative result.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = shifted[W] | ~diff[W];
    rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// div_seq
// Sequential unsigned divider, DIVIDEND_W / DIVISOR_W (DIVIDEND_W = 2*DIVISOR_W),
// one quotient bit per cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : div_seq_if slave (start/operands in; busy, done, results, flags out)
module div_seq import div_seq_pkg::*; #(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input logic      clk,
  input logic      rst_n,
  div_seq_if.slave bus
);

  localparam int CW = cnt_width(DIVISOR_W);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic [DIVISOR_W-1:0]  quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;

  logic [DIVISOR_W-1:0]  dvd_hi;
  logic [DIVISOR_W-1:0]  dvd_lo;
  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_q;

  assign dvd_hi = bus.dividend[DIVIDEND_W-1:DIVISOR_W];
  assign dvd_lo = bus.dividend[DIVISOR_W-1:0];

  // quo_q doubles as the dividend shift register: its MSB feeds the step,
  // and each new quotient bit enters at the LSB, so after DIVISOR_W steps
  // it holds the quotient.
  div_step #(.W(DIVISOR_W)) u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[DIVISOR_W-1]),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Special cases are classified here but resolved one edge later
          // in RUN, so both exits land on edge A+1.
          state_d   = RUN;
          busy_d    = 1'b1;
          cnt_d     = '0;
          divisor_d = bus.divisor;
          rem_d     = dvd_hi;
          quo_d     = dvd_lo;
          dbz_d     = (bus.divisor == '0);
          ovf_d     = (bus.divisor != '0) && (dvd_hi >= bus.divisor);
        end
      end

      RUN: begin
        if (dbz_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          quo_d   = '1;
          rem_d   = quo_q;
        end else if (ovf_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          quo_d   = '1;
          rem_d   = '0;
        end else begin
          rem_d = step_rem;
          quo_d = {quo_q[DIVISOR_W-2:0], step_q};
          if (cnt_q == CW'(DIVISOR_W - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter DIVIDEND_W, default 50, dividend width; SHALL equal 2*DIVISOR_W.
REQ-002 Parameter DIVISOR_W, default 25, divisor, quotient and remainder width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: request a division; sampled only in IDLE.
REQ-006 Port dividend, input, DIVIDEND_W: unsigned dividend; sampled on the accepting edge.
REQ-007 Port divisor, input, DIVISOR_W: unsigned divisor; sampled on the accepting edge.
REQ-008 Port busy, output, 1: high while an accepted operation is in progress (RUN or DONE).
REQ-009 Port done, output, 1: one-cycle pulse marking the cycle in which the results are valid.
REQ-010 Port quotient, output, DIVISOR_W: unsigned quotient, registered.
REQ-011 Port remainder, output, DIVISOR_W: unsigned remainder, registered.
REQ-012 Port div_by_zero, output, 1: divisor was zero; valid with done and held afterwards.
REQ-013 Port overflow, output, 1: quotient does not fit in DIVISOR_W bits; valid with done and held afterwards.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE, using sequential radix-2 restoring division with one quotient bit per cycle.
REQ-015 In IDLE with start=1, the block SHALL register dividend and divisor on that edge (the accepting edge, edge A).
REQ-016 Normal case (divisor != 0 and dividend[DIVIDEND_W-1:DIVISOR_W] < divisor): the block SHALL enter RUN for DIVISOR_W iterations, MSB first.
REQ-017 In the normal case, the block SHALL enter DONE on edge A+DIVISOR_W, so done is high between edges A+25 and A+26.
REQ-018 Each iteration SHALL shift the partial remainder left one bit and bring in the next dividend bit.
REQ-019 Each iteration SHALL then trial-subtract the divisor using a DIVISOR_W+1-bit difference.
REQ-020 Each iteration SHALL set the quotient bit to 1 and keep the difference when it is non-negative; otherwise it SHALL set the bit to 0 and restore.
REQ-021 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
REQ-022 When divisor==0, the block SHALL go IDLE->DONE on edge A+1 with div_by_zero=1, quotient=all ones and remainder=dividend[DIVISOR_W-1:0].
REQ-023 When divisor!=0 and dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor, the block SHALL go IDLE->DONE on edge A+1 with overflow=1, quotient=all ones and remainder=0.
REQ-024 div_by_zero and overflow SHALL be mutually exclusive, and both SHALL be cleared on the next accepting edge.
REQ-025 DONE SHALL last exactly one cycle and then return to IDLE; done SHALL be high only in DONE.
REQ-026 start SHALL be ignored in RUN and DONE, with no queuing; a new operation is accepted on the first edge back in IDLE.
REQ-027 quotient, remainder and the flags SHALL hold their last values from DONE until the next accepting edge; in RUN they may show intermediate values and are valid only when done=1.
REQ-028 The iteration counter SHALL be ceil(log2(DIVISOR_W+1)) bits wide and SHALL never wrap within an operation.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force state IDLE and drive busy, done, quotient, remainder, div_by_zero, overflow and the counter to 0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL be processed normally.

Structure
REQ-031 A shared package SHALL hold the DIVIDEND_W/DIVISOR_W defaults, the state encoding (IDLE=0, RUN=1, DONE=2) and the counter width constant.
REQ-032 One combinational sub-module, div_step, SHALL implement a single shift/trial-subtract/restore iteration; div_seq SHALL hold the FSM, counter and registers.
REQ-033 No multiplier or combinational divider SHALL be inferred.

Verification
REQ-034 dividend=1000, divisor=7 -> quotient=142, remainder=6, both flags 0, done exactly 25 edges after acceptance.
REQ-035 dividend=2^50-2^26+1 (the product 0x1FFFFFF*0x1FFFFFF), divisor=0x1FFFFFF -> quotient=0x1FFFFFF, remainder=0, overflow=0.
REQ-036 divisor=0, dividend=50'h3_0000_0000_0005 -> done on edge A+1, div_by_zero=1, quotient=0x1FFFFFF, remainder=5.
REQ-037 dividend=2^25, divisor=1 -> done on edge A+1, overflow=1, quotient=0x1FFFFFF, remainder=0.
REQ-038 start=1 held with new operands during RUN of 100/9 -> the results of 100/9 are returned (11 r 1), and the new request is accepted only after DONE.
REQ-039 rst_n low at iteration 10 of 1000/7 -> all outputs 0 with no done pulse; a subsequent 1000/7 returns 142 r 6.
